// File: rtl/mem_arbiter.sv
// Two-requester block memory arbiter: icache (read-only) and dcache (read/write) share one memory port.
// Optional build macro MEM_ARBITER_DPRIO_EN: fixed dcache priority instead of round-robin on ties.
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              first_q, first_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] resp_q, resp_d;
  logic              pend_i, pend_d, gnt_sel;

  assign pend_i = i_read;
  assign pend_d = d_read | d_write;

`ifdef MEM_ARBITER_DPRIO_EN
  assign gnt_sel = pend_d ? GNT_D : GNT_I;
`else
  logic last_q, last_d;

  // On a tie, grant whoever did not win last; otherwise the sole requester.
  always_comb begin
    if (pend_i && pend_d) gnt_sel = ~last_q;
    else                  gnt_sel = pend_d ? GNT_D : GNT_I;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && (pend_i || pend_d)) last_d = gnt_sel;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_q <= GNT_D;
    else        last_q <= last_d;
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= GNT_I;
      first_q <= 1'b0;
      req_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      first_q <= first_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    first_d   = first_q;
    req_d     = req_q;
    resp_d    = resp_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_i || pend_d) begin
          gnt_d   = gnt_sel;
          first_d = 1'b1;
          state_d = ACCESS;
          if (gnt_sel == GNT_D) begin
            // read+write together is illegal; the write wins
            req_d.wr    = d_write;
            req_d.addr  = d_address;
            req_d.wdata = d_writedata;
          end else begin
            req_d.wr    = 1'b0;
            req_d.addr  = i_address;
          end
        end
      end
      ACCESS: begin
        mem_read  = ~req_q.wr;
        mem_write = req_q.wr;
        first_d   = 1'b0;
        // memory has not seen the strobe yet in the first cycle, so its busywait is not trusted
        if (!first_q && !mem_busywait) begin
          state_d = RESP;
          if (!req_q.wr) resp_d = mem_readdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_address   = req_q.addr;
  assign mem_writedata = req_q.wdata;
  assign i_readdata    = resp_q;
  assign d_readdata    = resp_q;
  assign i_busywait    = pend_i & ~(state_q == RESP && gnt_q == GNT_I);
  assign d_busywait    = pend_d & ~(state_q == RESP && gnt_q == GNT_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected grants/data; a monitor checks responses.
module tb_mem_arbiter;
  localparam int M = 5;
  localparam logic [127:0] V05 = {16{8'hA5}};
  localparam logic [127:0] V0A = 128'h0A0A_0A0A_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] V21 = 128'h2121_2121_DEAD_BEEF_0000_FFFF_1357_9BDF;
  localparam logic [127:0] W3F = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [127:0] X12 = 128'hCAFE_F00D_0BAD_BEEF_FACE_B00C_5EED_1234;

  logic         clock = 1'b0, reset = 1'b0;
  logic         i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [5:0]   i_address = '0, d_address = '0;
  logic [127:0] d_writedata = '0;
  logic [127:0] i_readdata, d_readdata, mem_writedata, mem_readdata;
  logic         i_busywait, d_busywait, mem_read, mem_write, mem_busywait;
  logic [5:0]   mem_address;

  mem_arbiter #(.ADDR_W(6), .DATA_W(128)) dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 clock = ~clock;

  // memory model: busywait high for the first M strobed cycles of each access
  logic [127:0] mem [64];
  int  mcnt = 0;
  bit  init_done = 1'b0;
  assign mem_busywait = (mem_read | mem_write) && (mcnt < M);
  assign mem_readdata = mem[mem_address];
  always @(posedge clock) begin
    if (!init_done) begin
      for (int k = 0; k < 64; k++) mem[k] <= '0;
      mem[6'h05] <= V05;
      mem[6'h0A] <= V0A;
      mem[6'h21] <= V21;
      init_done  <= 1'b1;
    end else if (mem_read | mem_write) begin
      if (mem_busywait) mcnt <= mcnt + 1;
      else begin
        mcnt <= 0;
        if (mem_write) mem[mem_address] <= mem_writedata;
      end
    end else mcnt <= 0;
  end

  int compared = 0, mismatched = 0;
  int cyc = 0, i_done_cyc = 0;
  int i_lo_cnt = 0, mr05_cnt = 0, d_bw_cnt = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit           who;
    bit           wr;
    logic [5:0]   addr;
    logic [127:0] data;
  } exp_t;
  exp_t sbq[$];

  task automatic push(input bit who, input bit wr, input logic [5:0] a, input logic [127:0] d);
    exp_t e;
    e.who = who; e.wr = wr; e.addr = a; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic pop_chk(input bit who, input logic [127:0] data);
    exp_t e;
    if (sbq.size() == 0) begin
      compared++; mismatched++;
      $display("FAIL unexpected_resp: requester %0d responded, nothing expected", who);
    end else begin
      e = sbq.pop_front();
      chk("resp_requester", 128'(who), 128'(e.who));
      if (!e.wr) chk("resp_readdata", data, e.data);
    end
  endtask

  // monitor: response cycles and memory-side strobes against the head of the scoreboard
  always @(negedge clock) begin
    if (reset) begin
      if (i_read && !i_busywait) begin i_lo_cnt++; pop_chk(1'b0, i_readdata); end
      if ((d_read | d_write) && !d_busywait) pop_chk(1'b1, d_readdata);
      if (mem_read && mem_address == 6'h05) mr05_cnt++;
      if (d_busywait) d_bw_cnt++;
      if (mem_read | mem_write) begin
        if (sbq.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_access: mem strobe addr %h", mem_address);
        end else begin
          chk("mem_write", 128'(mem_write), 128'(sbq[0].wr));
          chk("mem_read", 128'(mem_read), 128'(!sbq[0].wr));
          chk("mem_address", 128'(mem_address), 128'(sbq[0].addr));
          if (sbq[0].wr) chk("mem_writedata", mem_writedata, sbq[0].data);
        end
      end
    end
  end

  task automatic req_i(input logic [5:0] a);
    int n = 0;
    i_read = 1'b1; i_address = a;
    do begin @(negedge clock); n++; end while (i_busywait && n < 300);
    if (i_busywait) begin
      compared++; mismatched++;
      $display("FAIL i_timeout: busywait still %b after %0d cycles, need 0", i_busywait, n);
    end
    i_done_cyc = cyc;
    @(posedge clock); #1 i_read = 1'b0;
  endtask

  task automatic req_d(input bit rd, input bit wr, input logic [5:0] a, input logic [127:0] wd);
    int n = 0;
    d_read = rd; d_write = wr; d_address = a; d_writedata = wd;
    do begin @(negedge clock); n++; end while (d_busywait && n < 300);
    if (d_busywait) begin
      compared++; mismatched++;
      $display("FAIL d_timeout: busywait still %b after %0d cycles, need 0", d_busywait, n);
    end
    @(posedge clock); #1 begin d_read = 1'b0; d_write = 1'b0; end
  endtask

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, need completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel_cyc, n, s_ilo, s_mr, s_dbw;
    // reset state, and busywait rising combinationally while in reset
    repeat (3) @(posedge clock);
    #1;
    chk("rst_mem_read", 128'(mem_read), 128'(0));
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    chk("rst_i_readdata", i_readdata, '0);
    chk("rst_d_readdata", d_readdata, '0);
    chk("rst_i_busywait_idle", 128'(i_busywait), 128'(0));
    d_read = 1'b1; #1;
    chk("rst_d_busywait_req", 128'(d_busywait), 128'(1));
    d_read = 1'b0;
    @(posedge clock); #1 reset = 1'b1;

    // reset pulled mid-ACCESS; held icache read re-served afterwards
    push(1'b0, 1'b0, 6'h0A, V0A);
    fork
      req_i(6'h0A);
      begin
        n = 0;
        while (!mem_read && n < 20) begin @(negedge clock); n++; end
        chk("reach_access", 128'(mem_read), 128'(1));
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("midrst_mem_read", 128'(mem_read), 128'(0));
        chk("midrst_i_busywait", 128'(i_busywait), 128'(1));
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        rel_cyc = cyc;
      end
    join
    chk("midrst_latency_ge4", 128'((i_done_cyc - rel_cyc) >= 4), 128'(1));
    repeat (2) @(posedge clock); #1;

    // single icache read of 0x05
    s_ilo = i_lo_cnt; s_mr = mr05_cnt; s_dbw = d_bw_cnt;
    push(1'b0, 1'b0, 6'h05, V05);
    req_i(6'h05);
    repeat (2) @(posedge clock); #1;
    chk("i05_access_cycles", 128'(mr05_cnt - s_mr), 128'(M + 1));
    chk("i05_bw_low_cycles", 128'(i_lo_cnt - s_ilo), 128'(1));
    chk("i05_d_busywait", 128'(d_bw_cnt - s_dbw), 128'(0));

    // dcache write-back, readback, and read+write treated as write
    push(1'b1, 1'b1, 6'h3F, W3F);
    req_d(1'b0, 1'b1, 6'h3F, W3F);
    @(posedge clock); #1;
    push(1'b1, 1'b0, 6'h3F, W3F);
    req_d(1'b1, 1'b0, 6'h3F, '0);
    @(posedge clock); #1;
    push(1'b1, 1'b1, 6'h12, X12);
    req_d(1'b1, 1'b1, 6'h12, X12);
    @(posedge clock); #1;
    push(1'b1, 1'b0, 6'h12, X12);
    req_d(1'b1, 1'b0, 6'h12, '0);

    // simultaneous requests straight after reset
    do_reset();
`ifdef MEM_ARBITER_DPRIO_EN
    push(1'b1, 1'b0, 6'h05, V05);
    push(1'b0, 1'b0, 6'h21, V21);
`else
    push(1'b0, 1'b0, 6'h21, V21);
    push(1'b1, 1'b0, 6'h05, V05);
`endif
    fork
      req_i(6'h21);
      req_d(1'b1, 1'b0, 6'h05, '0);
    join
    @(posedge clock); #1;

    // icache alone, then a tie: dcache wins in both builds
    push(1'b0, 1'b0, 6'h0A, V0A);
    req_i(6'h0A);
    @(posedge clock); #1;
    push(1'b1, 1'b0, 6'h3F, W3F);
    push(1'b0, 1'b0, 6'h05, V05);
    fork
      req_i(6'h05);
      req_d(1'b1, 1'b0, 6'h3F, '0);
    join

    // back-to-back contention: two tie rounds from reset
    do_reset();
    for (int r = 0; r < 2; r++) begin
`ifdef MEM_ARBITER_DPRIO_EN
      push(1'b1, 1'b0, 6'h0A, V0A);
      push(1'b0, 1'b0, 6'h21, V21);
`else
      push(1'b0, 1'b0, 6'h21, V21);
      push(1'b1, 1'b0, 6'h0A, V0A);
`endif
      fork
        req_i(6'h21);
        req_d(1'b1, 1'b0, 6'h0A, '0);
      join
      @(posedge clock); #1;
    end

    // late icache request waits for the dcache transaction in flight
    push(1'b1, 1'b0, 6'h0A, V0A);
    push(1'b0, 1'b0, 6'h12, X12);
    fork
      req_d(1'b1, 1'b0, 6'h0A, '0);
      begin repeat (2) @(posedge clock); #1 req_i(6'h12); end
    join

    repeat (3) @(posedge clock); #1;
    chk("scoreboard_drained", 128'(sbq.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single block-wide main memory between the instruction cache (requester 0, read-only) and the data cache (requester 1, read/write refill and write-back).
- Each cache sees a memory-like port with read/write, block address, data and busywait. The arbiter serialises accesses onto the one downstream memory port.
- Sits between the icache/dcache refill FSMs and the unified memory model.

Parameters:
- ADDR_W, 6, block address width (word address bits above block offset)
- DATA_W, 128, block width in bits

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- i_read  in  1  icache block read request
- i_address  in  ADDR_W  icache block address
- i_readdata  out  DATA_W  icache refill data
- i_busywait  out  1  icache stall
- d_read  in  1  dcache block read request
- d_write  in  1  dcache block write request
- d_address  in  ADDR_W  dcache block address
- d_writedata  in  DATA_W  dcache write-back data
- d_readdata  out  DATA_W  dcache refill data
- d_busywait  out  1  dcache stall
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_W  memory block address
- mem_writedata  out  DATA_W  memory write data
- mem_readdata  in  DATA_W  memory read data
- mem_busywait  in  1  memory stall

Behaviour:
- Request handshake:
  - Requester x is pending when its read (or write, for the dcache) is high.
  - Requester holds the strobe, address and writedata stable until its busywait falls.
  - The requester must drop the strobe on the clock edge after busywait falls.
- Busywait is combinational: x_busywait = pending_x AND NOT (state==RESP AND grant==x).
  - Busywait rises in the same cycle as the request, including during reset.
- d_read and d_write both high is illegal. The arbiter treats it as d_write.
- State register is 2 bits.
  - IDLE:
    - No memory strobes.
    - If any request is pending, latch grant and go to ACCESS.
  - ACCESS:
    - mem_read/mem_write driven from the granted requester.
    - mem_address and mem_writedata are driven from registered copies captured at grant.
    - Stay in ACCESS for at least 2 cycles. mem_busywait is ignored in the first ACCESS cycle.
    - From the second cycle on, the first rising edge with mem_busywait==0 captures mem_readdata into the response register (reads only) and moves to RESP.
  - RESP:
    - Strobes low.
    - Granted requester's busywait is 0; its readdata shows the response register.
    - Next state IDLE unconditionally.
- Arbitration is round-robin.
  - When both are pending in IDLE, grant goes to the requester not granted last.
  - A single pending requester is always granted.
  - last_grant updates on entry to ACCESS.
- Latency with no contention and memory latency M cycles: request seen in IDLE, then M+1..M+2 ACCESS cycles, then 1 RESP cycle. Minimum total is 4 cycles from request to busywait low.
- A request that arrives during another's transaction waits. It is served at the next IDLE; no request is dropped.
- Readdata outputs hold their last value between responses. i_readdata and d_readdata are both driven from the shared response register.
- Reset (reset==0, asynchronous), mid-transaction included:
  - state=IDLE, mem_read=0, mem_write=0, last_grant=dcache (icache wins the first tie).
  - Response register = 0.
  - Any in-flight memory access is abandoned; the requester keeps busywait high and is re-served after reset releases.
- mem_address/mem_writedata hold their value outside ACCESS (no X driving).

Optional Feature:
- Macro MEM_ARBITER_DPRIO_EN.
- Defined: fixed priority. When both are pending in IDLE the dcache always wins; last_grant is unused.
- Undefined: round-robin as above.
- Handshake, latency and reset behaviour are identical in both builds.

Test Plan:
- Reset low mid-ACCESS: mem_read drops immediately; after release, the held i_read is reissued. i_busywait falls ≥4 cycles after release.
- Single icache read, addr 6'h05, memory returns 128'hA5…A5 after M=5 cycles:
  - mem_read=1 with mem_address=6'h05 for ≥6 cycles.
  - i_busywait low for exactly 1 cycle; i_readdata=A5…A5 in that cycle.
  - d_busywait stays 0.
- dcache write-back to 6'h3F, data 128'h1234… : mem_write=1, mem_address=6'h3F, mem_writedata=1234… throughout ACCESS; d_busywait falls after memory completes.
- i_read and d_read asserted in the same cycle after reset:
  - Round-robin build: icache served first, then dcache.
  - MEM_ARBITER_DPRIO_EN build: dcache first.
  - The second requester's busywait stays high until its own RESP.
- Back-to-back contention, 4 alternating requests:
  - Round-robin build: grants alternate i,d,i,d.
  - MEM_ARBITER_DPRIO_EN build with d re-requesting immediately: d wins each tie.
